verintc: RTL
============

# verintc

- Bus-attached interrupt controller.
- Merges up to 31 device interrupt lines (Vertimer, UART, GPIO, …) into the single CPU interrupt line.
- Per-source functions: enable, edge/level mode, pending latch.
- Picks the highest-priority source and runs a claim/complete protocol, so one source is in service at a time.
- Sits on Verbus beside the other devices. Its `bus.irq` drives the core interrupt input.

## Interface

Parameters:
- `N_SOURCES`, default 8: number of interrupt inputs, legal range 1..31.

Ports:
- `bus.clk`, input, 1 bit: the single clock, carried in the Verbus interface.
- `bus.reset`, input, 1 bit: reset carried in the Verbus interface. Synchronous and active-high.
- `bus`, modport `read_write_response`: register access.
  - `bus.rdata`, `bus.ready` and `bus.irq` are driven by this block.
- `irq_in`, input, `N_SOURCES` bits: device interrupt requests. All are synchronous to `bus.clk`.

## Operation

Decoding:
- Local address is `bus.address[2+:3]`.
- Unlisted addresses read 0 and ignore writes.
- Source `i` has id `i+1`. Id 0 means "none".
- Lower index means higher priority.

Register map:
- 0 ENABLE: RW. Bit `i` set means source `i` may raise `irq`. Writes use byte-enable merge (`write_into`).
- 1 MODE: RW. Bit `i` = 1 means rising-edge triggered; 0 means level triggered. Byte-enable merge.
- 2 PENDING: read shows the pending vector. Write is write-1-to-clear (`clear_into`).
- 3 CLAIM:
  - Read: id of the highest-priority source that is pending and enabled, else 0. Combinational.
  - Write (state PENDING only): the written id must equal the current CLAIM value. If so, the pending bit is cleared, `in_service_id` takes the id, and the state goes to SERVICE. A mismatched or zero id is ignored.
- 4 COMPLETE:
  - Read: `in_service_id`, which is 0 when idle.
  - Write (state SERVICE only): a value equal to `in_service_id` returns the state to IDLE and clears `in_service_id`. Any other value is ignored.

Pending set rules:
- Edge mode: set when `irq_in[i] & ~prev[i]`. `prev` is registered every cycle.
- Level mode: set every cycle `irq_in[i]` is high.
- A pending bit latches regardless of ENABLE.

Priority:
- When the same bit is both set and cleared in one cycle (W1C or claim), the set wins.

State machine:
- IDLE → PENDING when `|(pending & enable)`.
- PENDING → IDLE if that condition drops, e.g. SW masks or clears the bit.
- PENDING → SERVICE on a valid CLAIM write.
- SERVICE → IDLE on a valid COMPLETE write.
- No nesting or preemption. Pending bits keep accumulating during SERVICE.

Outputs:
- `bus.irq = (state == PENDING)`.
- `bus.ready` is constant 1.
- `bus.rdata` is combinational from `local_address`.

## Timing

Reset values (`bus.reset` high at a clock edge):
- ENABLE, MODE, PENDING, `prev`, `in_service_id` all become 0. State becomes IDLE.
- Therefore `irq` = 0 and CLAIM reads 0.
- Reset mid-SERVICE aborts the service silently.

Latency:
- Edge or level on `irq_in` in cycle n → pending bit visible in cycle n+1 → state PENDING and `irq` = 1 in cycle n+2.
- Valid CLAIM write in cycle n → `irq` = 0 from cycle n+1. COMPLETE reads the id from cycle n+1.
- Valid COMPLETE write in cycle n → IDLE in cycle n+1. If other sources are pending and enabled, `irq` = 1 again in cycle n+2.

Register writes take effect on the next clock edge. Zero wait states.

## Structure

Package `Verintc_pkg` holds:
- `LOCAL_ADDRESS_WIDTH` = 3;
- `local_address_t` and the address constants (ENABLE, MODE, PENDING, CLAIM, COMPLETE);
- `state_t` {IDLE, PENDING, SERVICE};
- `MAX_SOURCES` = 31.

Sub-module `Verintc_priority_encoder`:
- Parameterized by `N_SOURCES`.
- Input: masked pending vector. Output: id (5 bits, 0 = none). Purely combinational.

## Test plan

- Reset, then read all five registers: all return 0, `irq` = 0.
- ENABLE=0x05, MODE=0x01, pulse `irq_in[0]` for 1 cycle:
  - `irq` = 1 two cycles later, CLAIM reads 1;
  - write CLAIM=1: `irq` = 0, COMPLETE reads 1;
  - write COMPLETE=1: COMPLETE reads 0.
- Set `irq_in[2]` and `irq_in[0]` together, both enabled: CLAIM reads 1. Claim then complete 1: CLAIM reads 3 and `irq` re-asserts.
- Invalid ids:
  - write CLAIM=2 while CLAIM reads 1: ignored, `irq` stays 1;
  - in SERVICE(1), write COMPLETE=3: ignored.
- Edge source: new `irq_in[0]` rising edge in the same cycle as a W1C of PENDING bit 0: PENDING bit 0 remains 1.
- Level source `irq_in[1]` held high: SERVICE(1) with source 1 still high → COMPLETE → `irq` = 1 again. Assert reset mid-SERVICE: `irq` = 0, COMPLETE reads 0.

Source files
------------

// File: rtl/verintc_pkg.sv
// Shared types, register addresses and byte-lane helpers for the verintc
// interrupt controller.
package verintc_pkg;

  localparam int LOCAL_ADDRESS_WIDTH = 3;
  localparam int MAX_SOURCES         = 31;
  localparam int ID_WIDTH            = 5;

  typedef logic [LOCAL_ADDRESS_WIDTH-1:0] local_address_t;

  localparam local_address_t ADDR_ENABLE   = 3'd0;
  localparam local_address_t ADDR_MODE     = 3'd1;
  localparam local_address_t ADDR_PENDING  = 3'd2;
  localparam local_address_t ADDR_CLAIM    = 3'd3;
  localparam local_address_t ADDR_COMPLETE = 3'd4;

  typedef enum logic [1:0] {IDLE, PENDING, SERVICE} state_t;

  function automatic logic [31:0] write_into(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byte_enable);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = byte_enable[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
    end
    return result;
  endfunction

  // Write-1-to-clear restricted to the enabled byte lanes.
  function automatic logic [31:0] clear_into(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  byte_enable);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = byte_enable[b] ? (old_val[8*b +: 8] & ~wdata[8*b +: 8])
                                        : old_val[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/verintc_if.sv
// Verbus slave-side bundle: clock, reset, register access and interrupt out.
interface verintc_if (
  input logic clk,
  input logic reset
);
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  byte_enable;
  logic        write;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  modport read_write_response (
    input  clk, reset, address, wdata, byte_enable, write,
    output rdata, ready, irq
  );

  modport master (
    input  clk, reset, rdata, ready, irq,
    output address, wdata, byte_enable, write
  );
endinterface

// File: rtl/verintc_priority_encoder.sv
// Returns the id (index+1) of the lowest-index set request, 0 when none.
module verintc_priority_encoder
  import verintc_pkg::*;
#(
  parameter int N_SOURCES = 8
) (
  input  logic [N_SOURCES-1:0] req,
  output logic [ID_WIDTH-1:0]  id
);

  always_comb begin
    id = '0;
    for (int i = N_SOURCES - 1; i >= 0; i--) begin
      if (req[i]) id = ID_WIDTH'(i + 1);
    end
  end

endmodule

// File: rtl/verintc.sv
// Interrupt controller: per-source enable/mode/pending, priority selection
// and a claim/complete handshake that keeps one source in service at a time.
module verintc
  import verintc_pkg::*;
#(
  parameter int N_SOURCES = 8
) (
  verintc_if.read_write_response bus,
  input logic [N_SOURCES-1:0]    irq_in
);

  logic [N_SOURCES-1:0] enable_q, enable_d;
  logic [N_SOURCES-1:0] mode_q, mode_d;
  logic [N_SOURCES-1:0] pending_q, pending_d;
  logic [N_SOURCES-1:0] prev_q, prev_d;
  logic [ID_WIDTH-1:0]  in_service_id_q, in_service_id_d;
  state_t               state_q, state_d;

  local_address_t       local_address;
  logic [ID_WIDTH-1:0]  claim_id;
  logic [N_SOURCES-1:0] set_vec, claim_mask;
  logic [31:0]          enable_wr, mode_wr, pending_wr;
  logic                 claim_valid, complete_valid, any_request;
  logic                 unused_bits;

  assign local_address = bus.address[2 +: LOCAL_ADDRESS_WIDTH];
  assign any_request   = |(pending_q & enable_q);

  verintc_priority_encoder #(.N_SOURCES(N_SOURCES)) u_encoder (
    .req (pending_q & enable_q),
    .id  (claim_id)
  );

  assign claim_valid    = bus.write && (local_address == ADDR_CLAIM) && (state_q == PENDING)
                          && (claim_id != '0) && (bus.wdata == 32'(claim_id));
  assign complete_valid = bus.write && (local_address == ADDR_COMPLETE) && (state_q == SERVICE)
                          && (bus.wdata == 32'(in_service_id_q));

  // prev_q holds last cycle's inputs so edge sources see only rising transitions.
  for (genvar gi = 0; gi < N_SOURCES; gi++) begin : g_src
    assign set_vec[gi]    = mode_q[gi] ? (irq_in[gi] & ~prev_q[gi]) : irq_in[gi];
    assign claim_mask[gi] = claim_valid && (claim_id == ID_WIDTH'(gi + 1));
  end

  assign enable_wr  = write_into(32'(enable_q), bus.wdata, bus.byte_enable);
  assign mode_wr    = write_into(32'(mode_q), bus.wdata, bus.byte_enable);
  assign pending_wr = clear_into(32'(pending_q), bus.wdata, bus.byte_enable);
  assign unused_bits = ^{bus.address[31:5], bus.address[1:0], enable_wr, mode_wr, pending_wr};

  always_comb begin
    enable_d        = enable_q;
    mode_d          = mode_q;
    prev_d          = irq_in;
    in_service_id_d = in_service_id_q;
    state_d         = state_q;

    if (bus.write && local_address == ADDR_ENABLE) enable_d = enable_wr[N_SOURCES-1:0];
    if (bus.write && local_address == ADDR_MODE)   mode_d   = mode_wr[N_SOURCES-1:0];

    // Clears first, sets last: a fresh request beats a W1C or claim in the same cycle.
    pending_d = (bus.write && local_address == ADDR_PENDING) ? pending_wr[N_SOURCES-1:0]
                                                             : pending_q;
    pending_d = (pending_d & ~claim_mask) | set_vec;

    case (state_q)
      IDLE:    if (any_request) state_d = PENDING;
      PENDING: begin
        if (claim_valid) begin
          state_d         = SERVICE;
          in_service_id_d = claim_id;
        end else if (!any_request) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (complete_valid) begin
          state_d         = IDLE;
          in_service_id_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus.clk) begin
    if (bus.reset) begin
      enable_q        <= '0;
      mode_q          <= '0;
      pending_q       <= '0;
      prev_q          <= '0;
      in_service_id_q <= '0;
      state_q         <= IDLE;
    end else begin
      enable_q        <= enable_d;
      mode_q          <= mode_d;
      pending_q       <= pending_d;
      prev_q          <= prev_d;
      in_service_id_q <= in_service_id_d;
      state_q         <= state_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (local_address)
      ADDR_ENABLE:   bus.rdata = 32'(enable_q);
      ADDR_MODE:     bus.rdata = 32'(mode_q);
      ADDR_PENDING:  bus.rdata = 32'(pending_q);
      ADDR_CLAIM:    bus.rdata = 32'(claim_id);
      ADDR_COMPLETE: bus.rdata = 32'(in_service_id_q);
      default:       bus.rdata = '0;
    endcase
  end

  assign bus.ready = 1'b1;
  assign bus.irq   = (state_q == PENDING);

endmodule
